// File: rtl/gate_drive_guard.sv
// gate_drive_guard: dead-time, shoot-through and max on-time protection between the
// dpwm complementary commands and the gate-driver pins, with a latched cause-coded fault.
module gate_drive_guard #(
   parameter int MIN_DT   = 4,
   parameter int MAX_ON   = 2047,
   parameter int OVL_FILT = 2
) (
   input  logic       i_clk,
   input  logic       reset,
   input  logic       i_enable,
   input  logic       i_c1,
   input  logic       i_c2,
   input  logic       i_fault_clr,
   output logic       o_g1,
   output logic       o_g2,
   output logic       o_fault,
   output logic [1:0] o_fault_code,
   output logic       o_active
);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_ON1   = 2'd1,
      S_ON2   = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [7:0]  DT_LIM   = 8'(MIN_DT);
   localparam logic [11:0] ON_LIM   = 12'(MAX_ON - 1);
   localparam logic [3:0]  OVL_LIM  = 4'(OVL_FILT);
   localparam logic [1:0]  CODE_OVL = 2'b01;
   localparam logic [1:0]  CODE_MAX = 2'b10;

   logic        r_c1_p0;
   logic        r_c2_p0;
   state_t      r_state_p1;
   logic [7:0]  r_dt_cnt_p1;
   logic [11:0] r_on_cnt_p1;
   logic [3:0]  r_ovl_cnt_p1;
   logic [7:0]  w_dt_next;
   logic [3:0]  w_ovl_next;
   logic        w_overlap;
   logic        w_cmd;
   logic        w_clr_ok;

   function automatic logic [7:0] sat_inc_dt(input logic [7:0] v, input logic [7:0] lim);
      return (v >= lim) ? lim : v + 8'd1;
   endfunction

   function automatic logic [11:0] sat_inc_on(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   function automatic logic [3:0] sat_inc_ovl(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // The dead-time count includes the current OFF cycle, so a gate rises on the edge
   // that completes MIN_DT cycles with both gates low.
   assign w_dt_next  = sat_inc_dt(r_dt_cnt_p1, DT_LIM);
   assign w_ovl_next = sat_inc_ovl(r_ovl_cnt_p1);
   assign w_overlap  = r_c1_p0 & r_c2_p0;
   assign w_cmd      = (r_state_p1 == S_ON2) ? r_c2_p0 : r_c1_p0;
   assign w_clr_ok   = i_fault_clr & ~r_c1_p0 & ~r_c2_p0;

   // p0: command capture
   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_c1_p0 <= 1'b0;
         r_c2_p0 <= 1'b0;
      end else begin
         r_c1_p0 <= i_c1;
         r_c2_p0 <= i_c2;
      end
   end

   // p1: guard state machine with registered gate and status outputs
   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_state_p1   <= S_OFF;
         r_dt_cnt_p1  <= '0;
         r_on_cnt_p1  <= '0;
         r_ovl_cnt_p1 <= '0;
         o_g1         <= 1'b0;
         o_g2         <= 1'b0;
         o_fault      <= 1'b0;
         o_fault_code <= 2'b00;
         o_active     <= 1'b0;
      end else if (r_state_p1 == S_FAULT) begin
         if (w_clr_ok) begin
            r_state_p1   <= S_OFF;
            r_dt_cnt_p1  <= '0;
            r_on_cnt_p1  <= '0;
            r_ovl_cnt_p1 <= '0;
            o_fault      <= 1'b0;
            o_fault_code <= 2'b00;
         end
      end else if (!i_enable) begin
         r_state_p1   <= S_OFF;
         r_dt_cnt_p1  <= '0;
         r_on_cnt_p1  <= '0;
         r_ovl_cnt_p1 <= '0;
         o_g1         <= 1'b0;
         o_g2         <= 1'b0;
         o_active     <= 1'b0;
      end else if (w_overlap) begin
         r_dt_cnt_p1  <= '0;
         r_on_cnt_p1  <= '0;
         r_ovl_cnt_p1 <= w_ovl_next;
         o_g1         <= 1'b0;
         o_g2         <= 1'b0;
         o_active     <= 1'b0;
         if (w_ovl_next >= OVL_LIM) begin
            r_state_p1   <= S_FAULT;
            o_fault      <= 1'b1;
            o_fault_code <= CODE_OVL;
         end else begin
            r_state_p1 <= S_OFF;
         end
      end else begin
         r_ovl_cnt_p1 <= '0;
         if (r_state_p1 == S_OFF) begin
            if ((r_c1_p0 | r_c2_p0) && (w_dt_next >= DT_LIM)) begin
               r_state_p1  <= r_c1_p0 ? S_ON1 : S_ON2;
               r_on_cnt_p1 <= '0;
               o_g1        <= r_c1_p0;
               o_g2        <= r_c2_p0;
               o_active    <= 1'b1;
            end else begin
               r_dt_cnt_p1 <= w_dt_next;
            end
         end else if (!w_cmd) begin
            r_state_p1  <= S_OFF;
            r_dt_cnt_p1 <= '0;
            o_g1        <= 1'b0;
            o_g2        <= 1'b0;
            o_active    <= 1'b0;
         end else if (r_on_cnt_p1 == ON_LIM) begin
            r_state_p1   <= S_FAULT;
            o_g1         <= 1'b0;
            o_g2         <= 1'b0;
            o_active     <= 1'b0;
            o_fault      <= 1'b1;
            o_fault_code <= CODE_MAX;
         end else begin
            r_on_cnt_p1 <= sat_inc_on(r_on_cnt_p1);
         end
      end
   end

endmodule

// File: tb/tb_gate_drive_guard.sv
// Bench for gate_drive_guard: per-cycle stimulus tables; each cycle's expected outputs
// are queued when driven and compared when they emerge two clock edges later.
module tb_gate_drive_guard;

   localparam logic [5:0] E_IDLE = 6'b000000;
   localparam logic [5:0] E_G1   = 6'b100001;
   localparam logic [5:0] E_G2   = 6'b010001;
   localparam logic [5:0] E_FOVL = 6'b001010;
   localparam logic [5:0] E_FMAX = 6'b001100;

   typedef struct packed {
      logic       c1;
      logic       c2;
      logic       en;
      logic       clr;
      logic       rst;
      logic [5:0] x;
   } stim_t;

   logic       i_clk       = 1'b0;
   logic       reset       = 1'b1;
   logic       i_enable    = 1'b1;
   logic       i_c1        = 1'b0;
   logic       i_c2        = 1'b0;
   logic       i_fault_clr = 1'b0;
   logic       o_g1;
   logic       o_g2;
   logic       o_fault;
   logic [1:0] o_fault_code;
   logic       o_active;
   logic [5:0] w_out;

   int         n_chk = 0;
   int         n_err = 0;
   stim_t      st[$];
   logic [5:0] sb[$];

   gate_drive_guard #(.MIN_DT(4), .MAX_ON(2047), .OVL_FILT(2)) dut (
      .i_clk       (i_clk),
      .reset       (reset),
      .i_enable    (i_enable),
      .i_c1        (i_c1),
      .i_c2        (i_c2),
      .i_fault_clr (i_fault_clr),
      .o_g1        (o_g1),
      .o_g2        (o_g2),
      .o_fault     (o_fault),
      .o_fault_code(o_fault_code),
      .o_active    (o_active)
   );

   assign w_out = {o_g1, o_g2, o_fault, o_fault_code, o_active};

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      n_chk++;
      if (o_g1 === 1'b1 && o_g2 === 1'b1) begin
         n_err++;
         $display("FAIL shoot_through t=%0t g1=%b g2=%b, both high not allowed", $time, o_g1, o_g2);
      end
   end

   task automatic add(input logic c1, input logic c2, input logic en, input logic clr,
                      input logic rst, input logic [5:0] x, input int n);
      stim_t s;
      s.c1 = c1; s.c2 = c2; s.en = en; s.clr = clr; s.rst = rst; s.x = x;
      repeat (n) st.push_back(s);
   endtask

   task automatic test_reset();
      reset = 1'b1; i_enable = 1'b1; i_c1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         if (i == 3) i_c1 = 1'b0;
         n_chk++;
         if (w_out !== 6'b000000) begin
            n_err++;
            $display("FAIL reset cyc=%0d out=%b expected=000000", i, w_out);
         end
      end
   endtask

   task automatic test_mirror();
      stim_t s; logic [5:0] e;
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      add(1, 0, 1, 0, 0, E_G1, 5);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      add(0, 1, 1, 0, 0, E_G2, 5);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      add(1, 0, 1, 0, 0, E_G1, 3);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL mirror t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_deadtime();
      stim_t s; logic [5:0] e;
      add(1, 0, 1, 0, 0, E_G1, 6);
      add(0, 0, 1, 0, 0, E_IDLE, 2);
      add(0, 1, 1, 0, 0, E_IDLE, 2);
      add(0, 1, 1, 0, 0, E_G2, 4);
      add(0, 0, 1, 0, 0, E_IDLE, 8);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL deadtime t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_overlap();
      stim_t s; logic [5:0] e;
      add(1, 0, 1, 0, 0, E_G1, 6);
      add(1, 1, 1, 0, 0, E_IDLE, 1);
      add(1, 0, 1, 0, 0, E_IDLE, 3);
      add(1, 0, 1, 0, 0, E_G1, 3);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      add(1, 1, 1, 0, 0, E_IDLE, 1);
      add(1, 1, 1, 0, 0, E_FOVL, 1);
      add(0, 0, 1, 0, 0, E_FOVL, 3);
      add(0, 0, 1, 0, 0, E_IDLE, 1);
      add(0, 0, 1, 1, 0, E_IDLE, 1);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL overlap t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_max_on();
      stim_t s; logic [5:0] e;
      add(1, 0, 1, 0, 0, E_G1, 2047);
      add(1, 0, 1, 0, 0, E_FMAX, 953);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL max_on t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_fault_clear();
      stim_t s; logic [5:0] e;
      add(1, 0, 1, 1, 0, E_FMAX, 4);
      add(0, 0, 1, 1, 0, E_IDLE, 2);
      add(1, 0, 1, 0, 0, E_IDLE, 2);
      add(1, 0, 1, 0, 0, E_G1, 4);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL fault_clear t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_disable();
      stim_t s; logic [5:0] e;
      add(1, 0, 1, 0, 0, E_G1, 5);
      add(1, 0, 1, 0, 0, E_IDLE, 1);
      add(1, 0, 0, 0, 0, E_IDLE, 2);
      add(1, 0, 1, 0, 0, E_IDLE, 2);
      add(1, 0, 1, 0, 0, E_G1, 2);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      add(1, 1, 0, 0, 0, E_IDLE, 2);
      add(0, 0, 0, 0, 0, E_IDLE, 2);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL disable t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_reset_mid();
      stim_t s; logic [5:0] e;
      add(1, 1, 1, 0, 0, E_IDLE, 1);
      add(1, 1, 1, 0, 0, E_FOVL, 1);
      add(0, 0, 1, 0, 0, E_FOVL, 2);
      add(0, 0, 1, 0, 0, E_IDLE, 1);
      add(1, 0, 1, 0, 1, E_IDLE, 3);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      add(1, 0, 1, 0, 0, E_G1, 3);
      add(1, 0, 1, 0, 0, E_IDLE, 1);
      add(1, 0, 1, 0, 1, E_IDLE, 2);
      add(1, 0, 1, 0, 0, E_IDLE, 2);
      add(0, 0, 1, 0, 0, E_IDLE, 6);
      while (st.size() > 0) begin
         s = st.pop_front();
         @(negedge i_clk);
         if (sb.size() == 2) begin
            e = sb.pop_front();
            n_chk++;
            if (w_out !== e) begin
               n_err++;
               $display("FAIL reset_mid t=%0t out=%b expected=%b", $time, w_out, e);
            end
         end
         {i_c1, i_c2, i_enable, i_fault_clr, reset} = {s.c1, s.c2, s.en, s.clr, s.rst};
         sb.push_back(s.x);
      end
   endtask

   task automatic test_drain();
      logic [5:0] e;
      while (sb.size() > 0) begin
         @(negedge i_clk);
         e = sb.pop_front();
         n_chk++;
         if (w_out !== e) begin
            n_err++;
            $display("FAIL drain t=%0t out=%b expected=%b", $time, w_out, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mirror();
      test_deadtime();
      test_overlap();
      test_max_on();
      test_fault_clear();
      test_disable();
      test_reset_mid();
      test_drain();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
